// File: rtl/hawk_pkg.sv
// Shared types and defaults for the hawk AXI master arbiter.
// Arbiter states and default sizing for the outstanding counters and the grant quota.
package hawk_pkg;

  typedef enum logic [1:0] {
    GRANT  = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } arb_state_t;

  localparam int HAWK_ARB_CNT_W = 4;
  localparam int HAWK_ARB_QUOTA = 8;

endpackage

// File: rtl/hawk_txn_counter.sv
// Up/down outstanding-transaction counter: saturates at all-ones, holds at zero and
// flags an underflow whenever a decrement arrives with nothing outstanding.
module hawk_txn_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             at_max_o,
  output logic             underflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             underflow_s;

  // Next-count computation with saturation at both ends.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    underflow_s = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_r != CNT_MAX) begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else if (dec_i && !inc_i) begin
      if (cnt_r != {CNT_W{1'b0}}) begin
        cnt_nxt_s = cnt_r - CNT_ONE;
      end else begin
        underflow_s = 1'b1;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign cnt_o       = cnt_r;
  assign cnt_nxt_o   = cnt_nxt_s;
  assign at_max_o    = (cnt_r == CNT_MAX);
  assign underflow_o = underflow_s;

endmodule

// File: rtl/hawk_axi_mstr_arbiter.sv
// Two-master crossbar select: round-robin with a per-grant quota, switching only once
// every outstanding write and read on the shared path has completed.
module hawk_axi_mstr_arbiter
  import hawk_pkg::*;
#(
  parameter int CNT_W        = HAWK_ARB_CNT_W,
  parameter int QUOTA        = HAWK_ARB_QUOTA,
  parameter bit DEFAULT_MSTR = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mstr0_req_i,
  input  logic mstr1_req_i,
  input  logic aw_hs_i,
  input  logic ar_hs_i,
  input  logic b_hs_i,
  input  logic r_last_hs_i,
  output logic mstr_sel_o,
  output logic aw_en_o,
  output logic ar_en_o,
  output logic busy_o,
  output logic err_o
);

  localparam int               TXN_W   = $clog2(QUOTA + 1);
  localparam logic [TXN_W:0]   QUOTA_L = (TXN_W + 1)'(QUOTA);

  arb_state_t       state_r;
  arb_state_t       state_nxt_s;
  logic             mstr_sel_r;
  logic             err_r;
  logic [TXN_W-1:0] txn_cnt_r;
  logic [TXN_W-1:0] txn_nxt_s;
  logic [TXN_W:0]   txn_sum_s;
  logic             quota_hit_s;
  logic             own_req_s;
  logic             peer_req_s;
  logic             err_set_s;

  logic [CNT_W-1:0] wr_cnt_s, wr_nxt_s, rd_cnt_s, rd_nxt_s;
  logic             wr_max_s, rd_max_s, wr_uf_s, rd_uf_s;

  hawk_txn_counter #(.CNT_W(CNT_W)) u_wr_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_i       (aw_hs_i),
    .dec_i       (b_hs_i),
    .cnt_o       (wr_cnt_s),
    .cnt_nxt_o   (wr_nxt_s),
    .at_max_o    (wr_max_s),
    .underflow_o (wr_uf_s)
  );

  hawk_txn_counter #(.CNT_W(CNT_W)) u_rd_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_i       (ar_hs_i),
    .dec_i       (r_last_hs_i),
    .cnt_o       (rd_cnt_s),
    .cnt_nxt_o   (rd_nxt_s),
    .at_max_o    (rd_max_s),
    .underflow_o (rd_uf_s)
  );

  // Enables and status decode only from registered state, never from inputs.
  assign aw_en_o    = (state_r == GRANT) && !wr_max_s;
  assign ar_en_o    = (state_r == GRANT) && !rd_max_s;
  assign busy_o     = (wr_cnt_s != {CNT_W{1'b0}}) || (rd_cnt_s != {CNT_W{1'b0}});
  assign mstr_sel_o = mstr_sel_r;
  assign err_o      = err_r;

  assign own_req_s  = mstr_sel_r ? mstr1_req_i : mstr0_req_i;
  assign peer_req_s = mstr_sel_r ? mstr0_req_i : mstr1_req_i;
  assign err_set_s  = wr_uf_s | rd_uf_s | (aw_hs_i & ~aw_en_o) | (ar_hs_i & ~ar_en_o);

  // Saturating quota count; the yield decision uses the post-update value so the
  // handshake that reaches the quota is the last one of the grant.
  always_comb begin
    txn_sum_s = {1'b0, txn_cnt_r} + {{TXN_W{1'b0}}, aw_hs_i} + {{TXN_W{1'b0}}, ar_hs_i};
    if (txn_sum_s >= QUOTA_L) begin
      txn_nxt_s = QUOTA_L[TXN_W-1:0];
    end else begin
      txn_nxt_s = txn_sum_s[TXN_W-1:0];
    end
    quota_hit_s = (txn_nxt_s == QUOTA_L[TXN_W-1:0]);
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      GRANT: begin
        if (peer_req_s && (quota_hit_s || !own_req_s)) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      DRAIN: begin
        if ((wr_nxt_s == {CNT_W{1'b0}}) && (rd_nxt_s == {CNT_W{1'b0}})) begin
          state_nxt_s = SWITCH;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      SWITCH:  state_nxt_s = GRANT;
      default: state_nxt_s = GRANT;
    endcase
  end

  // State, select, quota and sticky error registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= GRANT;
      mstr_sel_r <= DEFAULT_MSTR;
      txn_cnt_r  <= {TXN_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == DRAIN) && (state_nxt_s == SWITCH)) begin
        mstr_sel_r <= ~mstr_sel_r;
      end else begin
        mstr_sel_r <= mstr_sel_r;
      end
      txn_cnt_r <= (state_r == SWITCH) ? {TXN_W{1'b0}} : txn_nxt_s;
      err_r     <= err_r | err_set_s;
    end
  end

endmodule

// File: tb/tb_hawk_axi_mstr_arbiter.sv
// Directed table-driven bench for hawk_axi_mstr_arbiter plus round-robin and
// counter-saturation sequences.
module tb_hawk_axi_mstr_arbiter;

  logic clk_i = 1'b0;
  logic rst_i, mstr0_req_i, mstr1_req_i, aw_hs_i, ar_hs_i, b_hs_i, r_last_hs_i;
  logic mstr_sel_o, aw_en_o, ar_en_o, busy_o, err_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  hawk_axi_mstr_arbiter #(.CNT_W(4), .QUOTA(8), .DEFAULT_MSTR(1'b0)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mstr0_req_i (mstr0_req_i),
    .mstr1_req_i (mstr1_req_i),
    .aw_hs_i     (aw_hs_i),
    .ar_hs_i     (ar_hs_i),
    .b_hs_i      (b_hs_i),
    .r_last_hs_i (r_last_hs_i),
    .mstr_sel_o  (mstr_sel_o),
    .aw_en_o     (aw_en_o),
    .ar_en_o     (ar_en_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  // in = {rst, m0, m1, aw, ar, b, rlast}; ex = {sel, aw_en, ar_en, busy, err}
  typedef struct packed {
    logic [6:0] in;
    logic [4:0] ex;
  } vec_t;

  vec_t vecs [28];

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] in);
    {rst_i, mstr0_req_i, mstr1_req_i, aw_hs_i, ar_hs_i, b_hs_i, r_last_hs_i} = in;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    drive(7'b1000000);
    step();
    drive(7'b0000000);
  endtask

  int   gsel [8];
  int   gcnt [8];
  int   ng;
  logic prev_ar;

  initial begin
    vecs[0]  = '{7'b1000000, 5'b01100}; // reset state
    vecs[1]  = '{7'b0101000, 5'b01110}; // AW 1
    vecs[2]  = '{7'b0101000, 5'b01110}; // AW 2
    vecs[3]  = '{7'b0101000, 5'b01110}; // AW 3
    vecs[4]  = '{7'b0100010, 5'b01110}; // B -> 2
    vecs[5]  = '{7'b0101010, 5'b01110}; // AW+B -> 2
    vecs[6]  = '{7'b0000010, 5'b01110}; // B -> 1
    vecs[7]  = '{7'b0000010, 5'b01100}; // B -> 0
    vecs[8]  = '{7'b0000010, 5'b01101}; // underflow
    vecs[9]  = '{7'b0000000, 5'b01101}; // sticky
    vecs[10] = '{7'b1000000, 5'b01100}; // reset clears err
    vecs[11] = '{7'b0010000, 5'b00000}; // N: peer req -> DRAIN
    vecs[12] = '{7'b0010000, 5'b10000}; // SWITCH, sel toggled
    vecs[13] = '{7'b0010000, 5'b11100}; // GRANT m1
    vecs[14] = '{7'b0010100, 5'b11110}; // AR 1
    vecs[15] = '{7'b0010100, 5'b11110}; // AR 2
    vecs[16] = '{7'b0100000, 5'b10010}; // m1 idle, m0 req -> DRAIN
    vecs[17] = '{7'b0100001, 5'b10010}; // rlast -> 1, still DRAIN
    vecs[18] = '{7'b0000001, 5'b00000}; // rlast -> 0, SWITCH despite peer drop
    vecs[19] = '{7'b0000000, 5'b01100}; // GRANT m0
    vecs[20] = '{7'b0010000, 5'b00000}; // DRAIN
    vecs[21] = '{7'b0011000, 5'b00011}; // AW during DRAIN: counted, err
    vecs[22] = '{7'b0000010, 5'b10001}; // B drains -> SWITCH
    vecs[23] = '{7'b1000000, 5'b01100}; // reset
    vecs[24] = '{7'b0101000, 5'b01110}; // AW 1
    vecs[25] = '{7'b0010000, 5'b00010}; // DRAIN with write outstanding
    vecs[26] = '{7'b1000000, 5'b01100}; // reset mid-DRAIN
    vecs[27] = '{7'b0000000, 5'b01100}; // idle GRANT

    drive(7'b1000000);
    step();
    step();

    for (int i = 0; i < 28; i++) begin
      drive(vecs[i].in);
      step();
      chk("sel",    i, mstr_sel_o, vecs[i].ex[4]);
      chk("aw_en",  i, aw_en_o,    vecs[i].ex[3]);
      chk("ar_en",  i, ar_en_o,    vecs[i].ex[2]);
      chk("busy",   i, busy_o,     vecs[i].ex[1]);
      chk("err",    i, err_o,      vecs[i].ex[0]);
    end

    // Round robin: both masters request, one AR per enabled cycle, rlast a cycle later.
    do_reset();
    ng = 0;
    prev_ar = 1'b0;
    for (int c = 0; c < 60; c++) begin
      mstr0_req_i = 1'b1;
      mstr1_req_i = 1'b1;
      ar_hs_i     = ar_en_o;
      r_last_hs_i = prev_ar;
      if (ar_en_o) begin
        if ((ng == 0) || (gsel[ng-1] != int'(mstr_sel_o))) begin
          if (ng < 8) begin
            gsel[ng] = int'(mstr_sel_o);
            gcnt[ng] = 0;
            ng++;
          end
        end
        gcnt[ng-1]++;
      end
      prev_ar = ar_hs_i;
      step();
    end
    drive(7'b0000000);
    checks++;
    if (ng < 3) begin
      failures++;
      $display("FAIL rr_grants: got %0d grants expected at least 3", ng);
    end else begin
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (gcnt[g] != 8) begin
          failures++;
          $display("FAIL rr_count [%0d]: got %0d expected 8", g, gcnt[g]);
        end
        chk("rr_sel", g, gsel[g][0], (g == 1) ? 1'b1 : 1'b0);
      end
    end
    chk("rr_err", 0, err_o, 1'b0);

    // Write counter saturation and gating.
    do_reset();
    mstr0_req_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("aw_en_pre_max", i, aw_en_o, 1'b1);
      aw_hs_i = 1'b1;
      step();
    end
    aw_hs_i = 1'b0;
    chk("aw_en_at_max", 0, aw_en_o, 1'b0);
    chk("ar_en_at_max", 0, ar_en_o, 1'b1);
    chk("err_at_max",   0, err_o,   1'b0);
    aw_hs_i = 1'b1;
    step();
    aw_hs_i = 1'b0;
    chk("err_aw_disabled", 0, err_o,   1'b1);
    chk("aw_en_still_max", 0, aw_en_o, 1'b0);
    b_hs_i = 1'b1;
    for (int i = 0; i < 14; i++) step();
    chk("busy_after_14b", 0, busy_o,  1'b1);
    chk("aw_en_below_max", 0, aw_en_o, 1'b1);
    step();
    b_hs_i = 1'b0;
    chk("busy_after_15b", 0, busy_o, 1'b0);
    chk("err_sticky",     0, err_o,  1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
